// File: rtl/dmem_access_unit.sv
// Memory-stage data access controller: alignment checks, one bus transaction per
// load/store on a request/addr_ok/data_ok bus, load extension and pipeline stall.
module dmem_access_unit #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush_except,
  input  logic        stall_in,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_addr,
  output logic        stall_req,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

  function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lo, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (size)
      2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic              load_q, load_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cancel_q, cancel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;

  logic              is_load, is_store, misalign, start;
  logic [1:0]        size_dec;

  // Opcode decode and alignment check on the live M-stage inputs
  always_comb begin
    is_load  = (op[5:3] == 3'b100);
    is_store = (op[5:3] == 3'b101);
    case (op[1:0])
      2'b00:   size_dec = 2'd0;
      2'b01:   size_dec = 2'd1;
      default: size_dec = 2'd2;
    endcase
    misalign = ((size_dec == 2'd1) & addr[0]) |
               ((size_dec == 2'd2) & (addr[1:0] != 2'b00));
    adel     = mem_en & is_load & misalign;
    ades     = mem_en & is_store & misalign;
    bad_addr = addr;
    start    = mem_en & (is_load | is_store) & ~adel & ~ades & ~flush_except;
  end

  // Next-state, latch updates and stall/request decode
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    load_d    = load_q;
    uns_d     = uns_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cancel_d  = cancel_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    stall_req = 1'b0;
    data_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_REQ;
          wr_d      = is_store;
          load_d    = is_load;
          uns_d     = op[2];
          size_d    = size_dec;
          addr_d    = addr;
          wdata_d   = store_replicate(size_dec, wdata);
          stall_req = 1'b1;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_REQ: begin
        data_req  = 1'b1;
        stall_req = 1'b1;
        if (flush_except) begin
          state_d = S_IDLE;
        end else if (data_addr_ok) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          cancel_d = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q | flush_except) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (load_q) begin
              rdata_d = load_extend(size_q, uns_q, addr_q[1:0], data_rdata);
            end else begin
              rdata_d = rdata_q;
            end
          end
        end else begin
          cancel_d = cancel_q | flush_except;
          // Single pulse on the transition into TIMEOUT; the counter then saturates
          if (cnt_q != TMO) begin
            cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            bus_err_d = (cnt_q == TMO_M1);
          end else begin
            cnt_d     = cnt_q;
          end
        end
      end
      S_DONE: begin
        if (stall_in) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched-transaction registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      load_q    <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      cancel_q  <= 1'b0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      load_q    <= load_d;
      uns_q     <= uns_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cancel_q  <= cancel_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign rdata      = rdata_q;
  assign bus_err    = bus_err_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, address errors, bus stalls,
// flushes, reset mid-transaction and the wait-cycle watchdog.
module tb_dmem_access_unit;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  logic        clk = 1'b0;
  logic        rst, mem_en, flush_except, stall_in;
  logic [5:0]  op;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, bad_addr, data_addr, data_wdata, data_rdata;
  logic        adel, ades, stall_req, bus_err, data_req, data_wr;
  logic [1:0]  data_size;
  logic        data_addr_ok, data_ok;

  int vecs = 0;
  int errs = 0;

  dmem_access_unit #(.CNT_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .op(op), .addr(addr), .wdata(wdata),
    .flush_except(flush_except), .stall_in(stall_in), .rdata(rdata),
    .adel(adel), .ades(ades), .bad_addr(bad_addr), .stall_req(stall_req),
    .bus_err(bus_err), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_ok(data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    mem_en = 1'b0; flush_except = 1'b0; stall_in = 1'b0;
    data_addr_ok = 1'b0; data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic test_reset;
    rst = 1'b0; idle_inputs(); op = 6'd0; addr = 32'd0; wdata = 32'd0;
    tick(); tick(); #1;
    vecs++;
    if ({data_req, stall_req, bus_err, data_wr, data_size} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b want 000000", {data_req, stall_req, bus_err, data_wr, data_size}); errs++;
    end
    vecs++;
    if ({rdata, data_addr, data_wdata} !== 96'd0) begin
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want zeros", rdata, data_addr, data_wdata); errs++;
    end
    rst = 1'b1;
  endtask

  // Minimum-latency load: addr_ok in cycle1, data_ok in cycle2, result in cycle3
  task automatic run_load(input logic [5:0] o, input logic [31:0] a, input logic [31:0] bus,
                          input logic [1:0] sz, input logic [31:0] exp, input string nm);
    tick(); mem_en = 1'b1; op = o; addr = a; #1;
    vecs++;
    if ({stall_req, data_req} !== 2'b10) begin
      $display("FAIL %s_c0: stall/req=%b want 10", nm, {stall_req, data_req}); errs++;
    end
    tick(); data_addr_ok = 1'b1; #1;
    vecs++;
    if ({stall_req, data_req, data_wr, data_size, data_addr} !== {1'b1, 1'b1, 1'b0, sz, a}) begin
      $display("FAIL %s_c1: stall=%b req=%b wr=%b size=%0d addr=%h want 1 1 0 %0d %h",
               nm, stall_req, data_req, data_wr, data_size, data_addr, sz, a); errs++;
    end
    tick(); data_addr_ok = 1'b0; data_ok = 1'b1; data_rdata = bus; #1;
    vecs++;
    if ({stall_req, data_req} !== 2'b10) begin
      $display("FAIL %s_c2: stall/req=%b want 10", nm, {stall_req, data_req}); errs++;
    end
    tick(); data_ok = 1'b0; data_rdata = 32'd0; mem_en = 1'b0; #1;
    vecs++;
    if ({stall_req, data_req, rdata} !== {2'b00, exp}) begin
      $display("FAIL %s_c3: stall=%b req=%b rdata=%h want 0 0 %h", nm, stall_req, data_req, rdata, exp); errs++;
    end
    tick(); #1;
    vecs++;
    if ({stall_req, data_req} !== 2'b00) begin
      $display("FAIL %s_c4: stall/req=%b want 00", nm, {stall_req, data_req}); errs++;
    end
  endtask

  task automatic test_loads;
    run_load(OP_LW,  32'h8000_0010, 32'h1234_5678, 2'd2, 32'h1234_5678, "lw");
    run_load(OP_LB,  32'h8000_0022, 32'h0080_0000, 2'd0, 32'hFFFF_FF80, "lb");
    run_load(OP_LBU, 32'h8000_0022, 32'h0080_0000, 2'd0, 32'h0000_0080, "lbu");
    run_load(OP_LH,  32'h8000_0022, 32'h8001_0000, 2'd1, 32'hFFFF_8001, "lh");
  endtask

  task automatic run_store(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic [31:0] exp_wd, input string nm);
    logic [31:0] old_rdata;
    old_rdata = rdata;
    tick(); mem_en = 1'b1; op = o; addr = a; wdata = wd; #1;
    tick(); data_addr_ok = 1'b1; #1;
    vecs++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata} !== {1'b1, 1'b1, sz, a, exp_wd}) begin
      $display("FAIL %s_req: req=%b wr=%b size=%0d addr=%h wdata=%h want 1 1 %0d %h %h",
               nm, data_req, data_wr, data_size, data_addr, data_wdata, sz, a, exp_wd); errs++;
    end
    tick(); data_addr_ok = 1'b0; data_ok = 1'b1; data_rdata = 32'h5A5A_5A5A; #1;
    tick(); data_ok = 1'b0; mem_en = 1'b0; #1;
    vecs++;
    if ({stall_req, rdata} !== {1'b0, old_rdata}) begin
      $display("FAIL %s_done: stall=%b rdata=%h want 0 %h", nm, stall_req, rdata, old_rdata); errs++;
    end
    tick(); #1;
  endtask

  task automatic test_stores;
    run_store(OP_SB, 32'h8000_0021, 32'h0000_00AB, 2'd0, 32'hABAB_ABAB, "sb");
    run_store(OP_SH, 32'h8000_0022, 32'h7777_1234, 2'd1, 32'h1234_1234, "sh");
  endtask

  task automatic test_addr_err;
    tick(); mem_en = 1'b1; op = OP_SH; addr = 32'h8000_0103; #1;
    vecs++;
    if ({ades, adel, stall_req, data_req, bad_addr} !== {4'b1000, 32'h8000_0103}) begin
      $display("FAIL sh_misalign: ades=%b adel=%b stall=%b req=%b bad=%h want 1 0 0 0 80000103",
               ades, adel, stall_req, data_req, bad_addr); errs++;
    end
    tick(); op = OP_LW; addr = 32'h8000_0102; #1;
    vecs++;
    if ({adel, ades, stall_req, data_req, bad_addr} !== {4'b1000, 32'h8000_0102}) begin
      $display("FAIL lw_misalign: adel=%b ades=%b stall=%b req=%b bad=%h want 1 0 0 0 80000102",
               adel, ades, stall_req, data_req, bad_addr); errs++;
    end
    tick(); op = OP_LH; addr = 32'h8000_0101; #1;
    vecs++;
    if ({adel, ades, stall_req, data_req} !== 4'b1000) begin
      $display("FAIL lh_misalign: adel/ades/stall/req=%b want 1000", {adel, ades, stall_req, data_req}); errs++;
    end
    tick(); mem_en = 1'b0; #1;
    vecs++;
    if (data_req !== 1'b0) begin
      $display("FAIL err_no_req: req=%b want 0", data_req); errs++;
    end
  endtask

  // addr_ok held off for 4 REQ cycles, then stall_in keeps the FSM in DONE
  task automatic test_back_to_back;
    tick(); mem_en = 1'b1; op = OP_LW; addr = 32'h8000_0040; wdata = 32'h0BAD_F00D; #1;
    for (int i = 0; i < 4; i++) begin
      tick(); addr = 32'h8000_0080 + 32'(i * 4); wdata = 32'h1111_0000 + 32'(i); #1;
      vecs++;
      if ({data_req, stall_req, data_addr, data_wdata} !== {2'b11, 32'h8000_0040, 32'h0BAD_F00D}) begin
        $display("FAIL req_hold%0d: req=%b stall=%b addr=%h wdata=%h want 1 1 80000040 0badf00d",
                 i, data_req, stall_req, data_addr, data_wdata); errs++;
      end
    end
    tick(); data_addr_ok = 1'b1; #1;
    tick(); data_addr_ok = 1'b0; data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; #1;
    tick(); data_ok = 1'b0; data_rdata = 32'd0; stall_in = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if ({stall_req, data_req, rdata} !== {2'b00, 32'hCAFE_F00D}) begin
        $display("FAIL done_hold%0d: stall=%b req=%b rdata=%h want 0 0 cafef00d", i, stall_req, data_req, rdata); errs++;
      end
      tick(); #1;
    end
    stall_in = 1'b0; mem_en = 1'b0; #1;
    vecs++;
    if ({data_req, rdata} !== {1'b0, 32'hCAFE_F00D}) begin
      $display("FAIL done_release: req=%b rdata=%h want 0 cafef00d", data_req, rdata); errs++;
    end
    tick(); #1;
    vecs++;
    if ({stall_req, data_req} !== 2'b00) begin
      $display("FAIL no_second_req: stall/req=%b want 00", {stall_req, data_req}); errs++;
    end
  endtask

  task automatic test_flush;
    tick(); mem_en = 1'b1; op = OP_LW; addr = 32'h8000_0200; #1;
    tick(); flush_except = 1'b1; #1;
    tick(); flush_except = 1'b0; mem_en = 1'b0; #1;
    vecs++;
    if ({stall_req, data_req} !== 2'b00) begin
      $display("FAIL flush_req: stall/req=%b want 00", {stall_req, data_req}); errs++;
    end
    tick(); mem_en = 1'b1; op = OP_LW; addr = 32'h8000_0204; #1;
    tick(); data_addr_ok = 1'b1; #1;
    tick(); data_addr_ok = 1'b0; flush_except = 1'b1; mem_en = 1'b0; #1;
    tick(); flush_except = 1'b0; data_ok = 1'b1; data_rdata = 32'h5555_5555; #1;
    vecs++;
    if (stall_req !== 1'b1) begin
      $display("FAIL flush_wait_stall: stall=%b want 1", stall_req); errs++;
    end
    tick(); data_ok = 1'b0; #1;
    vecs++;
    if ({stall_req, data_req, rdata} !== {2'b00, 32'hCAFE_F00D}) begin
      $display("FAIL flush_wait: stall=%b req=%b rdata=%h want 0 0 cafef00d", stall_req, data_req, rdata); errs++;
    end
  endtask

  task automatic test_reset_wait;
    tick(); mem_en = 1'b1; op = OP_SB; addr = 32'h8000_0301; wdata = 32'h0000_00C3; #1;
    tick(); data_addr_ok = 1'b1; #1;
    tick(); data_addr_ok = 1'b0; rst = 1'b0; mem_en = 1'b0; #1;
    tick(); rst = 1'b1; #1;
    vecs++;
    if ({data_req, stall_req, bus_err, data_wr, data_size, data_addr, data_wdata, rdata} !== 102'd0) begin
      $display("FAIL reset_wait: req=%b stall=%b err=%b wr=%b size=%0d addr=%h wd=%h rdata=%h want all 0",
               data_req, stall_req, bus_err, data_wr, data_size, data_addr, data_wdata, rdata); errs++;
    end
    tick(); data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF; #1;
    tick(); data_ok = 1'b0; #1;
    vecs++;
    if ({stall_req, data_req, rdata} !== 34'd0) begin
      $display("FAIL stray_data_ok: stall=%b req=%b rdata=%h want 0 0 0", stall_req, data_req, rdata); errs++;
    end
  endtask

  task automatic test_timeout;
    int pulses;
    int first;
    int drops;
    pulses = 0; first = 0; drops = 0;
    tick(); mem_en = 1'b1; op = OP_LW; addr = 32'h8000_0400; #1;
    tick(); data_addr_ok = 1'b1; #1;
    for (int k = 1; k <= 300; k++) begin
      tick(); data_addr_ok = 1'b0; #1;
      if (bus_err === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (stall_req !== 1'b1) drops++;
    end
    vecs++;
    if (pulses !== 1 || first !== 256) begin
      $display("FAIL bus_err_pulse: pulses=%0d at wait cycle %0d want 1 at 256", pulses, first); errs++;
    end
    vecs++;
    if (drops !== 0) begin
      $display("FAIL timeout_stall: stall dropped %0d cycles want 0", drops); errs++;
    end
    tick(); data_ok = 1'b1; data_rdata = 32'h0F0F_0F0F; #1;
    tick(); data_ok = 1'b0; mem_en = 1'b0; #1;
    vecs++;
    if ({stall_req, bus_err, rdata} !== {2'b00, 32'h0F0F_0F0F}) begin
      $display("FAIL timeout_done: stall=%b err=%b rdata=%h want 0 0 0f0f0f0f", stall_req, bus_err, rdata); errs++;
    end
    tick(); #1;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_addr_err();
    test_back_to_back();
    test_flush();
    test_reset_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
